// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single-port instruction ROM between the core
// instruction-fetch port and the core data port. One access is granted per
// cycle; the registered ROM data is routed back to the winner one cycle later
// together with an error flag for writes and out-of-range word indices.
module rom_port_arbiter #(
  parameter int ROM_WORDS = 8192,  // ROM depth in 32-bit words
  parameter int DATA_PRIO = 1,     // 1: data port wins ties, 0: instr port wins ties
  parameter int MAX_WAIT  = 4      // lost cycles before the loser is forced to win (1..15)
) (
  input  logic        HCLK,
  input  logic        HRESET,
  // instruction fetch port
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  // data port
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  // ROM side
  output logic        rom_cs,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [3:0]  MAX_W       = 4'(MAX_WAIT);
  localparam logic [30:0] ROM_WORDS_W = 31'(ROM_WORDS);

  // response pipeline and starvation counters
  owner_e      owner_q, owner_d;
  logic        err_q, err_d;
  logic [3:0]  instr_wait_q, instr_wait_d;
  logic [3:0]  data_wait_q, data_wait_d;

  // arbitration results for the current cycle
  logic        instr_win;
  logic        data_win;
  logic        any_win;
  logic [31:0] win_addr;
  logic        in_range;
  logic        illegal;

  // Pick at most one winner; a port that has lost MAX_WAIT cycles in a row
  // overrides the default tie-break. Nothing is granted while in reset.
  always_comb begin
    instr_win = 1'b0;
    data_win  = 1'b0;
    if (!HRESET) begin
      if (instr_req && data_req) begin
        if (DATA_PRIO != 0) begin
          if (instr_wait_q == MAX_W) instr_win = 1'b1;
          else                       data_win  = 1'b1;
        end else begin
          if (data_wait_q == MAX_W)  data_win  = 1'b1;
          else                       instr_win = 1'b1;
        end
      end else begin
        instr_win = instr_req;
        data_win  = data_req;
      end
    end
  end

  // Legality check of the winning access and ROM-side drive.
  always_comb begin
    any_win  = instr_win || data_win;
    win_addr = data_win ? data_addr : instr_addr;
    in_range = {1'b0, win_addr[31:2]} < ROM_WORDS_W;
    illegal  = !in_range || (data_win && data_we);
    rom_cs   = any_win && !illegal;
    rom_addr = any_win ? win_addr : '0;
    instr_gnt = instr_win;
    data_gnt  = data_win;
  end

  // Next-state for the wait counters and the response pipeline.
  always_comb begin
    instr_wait_d = instr_wait_q;
    data_wait_d  = data_wait_q;
    owner_d      = OWN_NONE;
    err_d        = 1'b0;

    if (!instr_req || instr_win)  instr_wait_d = '0;
    else if (instr_wait_q < MAX_W) instr_wait_d = instr_wait_q + 4'd1;

    if (!data_req || data_win)    data_wait_d = '0;
    else if (data_wait_q < MAX_W)  data_wait_d = data_wait_q + 4'd1;

    if (instr_win)     owner_d = OWN_INSTR;
    else if (data_win) owner_d = OWN_DATA;
    err_d = any_win && illegal;
  end

  // State registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q      <= OWN_NONE;
      err_q        <= 1'b0;
      instr_wait_q <= '0;
      data_wait_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      err_q        <= err_d;
      instr_wait_q <= instr_wait_d;
      data_wait_q  <= data_wait_d;
    end
  end

  // Route the response to the owner; an in-flight response is dropped as soon
  // as reset is raised, so rvalid is also masked combinationally by HRESET.
  always_comb begin
    instr_rvalid = 1'b0;
    instr_err    = 1'b0;
    instr_rdata  = '0;
    data_rvalid  = 1'b0;
    data_err     = 1'b0;
    data_rdata   = '0;
    if (!HRESET) begin
      if (owner_q == OWN_INSTR) begin
        instr_rvalid = 1'b1;
        instr_err    = err_q;
        instr_rdata  = err_q ? '0 : rom_rdata;
      end else if (owner_q == OWN_DATA) begin
        data_rvalid  = 1'b1;
        data_err     = err_q;
        data_rdata   = err_q ? '0 : rom_rdata;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed testbench for rom_port_arbiter with a registered ROM model.
module tb_rom_port_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        rom_cs;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  rom_port_arbiter #(.ROM_WORDS(8192), .DATA_PRIO(1), .MAX_WAIT(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  always #5 HCLK = ~HCLK;

  // ROM contents: word 4 holds 0xDEADBEEF, others a word-dependent pattern.
  function automatic logic [31:0] rom_fn(input logic [29:0] w);
    if (w == 30'd4) return 32'hDEADBEEF;
    return {2'b00, w} ^ 32'h5A5A_0000;
  endfunction

  // Registered ROM: data appears the cycle after chip select.
  always @(posedge HCLK) if (rom_cs) rom_rdata <= rom_fn(rom_addr[31:2]);

  // Drive phase (just after the rising edge) and check phase (falling edge).
  task automatic drive_cycle(input logic rst, input logic ireq, input logic [31:0] ia,
                             input logic dreq, input logic [31:0] da, input logic we);
    @(posedge HCLK); #1;
    HRESET = rst; instr_req = ireq; instr_addr = ia;
    data_req = dreq; data_addr = da; data_we = we;
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
    drive_cycle(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
    n_checks++; if (instr_gnt !== 1'b0 || data_gnt !== 1'b0) begin
      $display("FAIL reset_gnt: got i=%b d=%b, want 0 0", instr_gnt, data_gnt); n_fail++; end
    n_checks++; if (rom_cs !== 1'b0) begin
      $display("FAIL reset_rom_cs: got %b, want 0", rom_cs); n_fail++; end
    n_checks++; if (instr_rvalid !== 1'b0 || data_rvalid !== 1'b0 || instr_err !== 1'b0 || data_err !== 1'b0) begin
      $display("FAIL reset_rvalid: got iv=%b dv=%b ie=%b de=%b, want 0", instr_rvalid, data_rvalid, instr_err, data_err); n_fail++; end
  endtask

  task automatic test_fetch();
    drive_cycle(1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
    n_checks++; if (instr_gnt !== 1'b1 || data_gnt !== 1'b0) begin
      $display("FAIL fetch_gnt: got i=%b d=%b, want 1 0", instr_gnt, data_gnt); n_fail++; end
    n_checks++; if (rom_cs !== 1'b1 || rom_addr !== 32'h10) begin
      $display("FAIL fetch_rom: got cs=%b addr=%h, want 1 00000010", rom_cs, rom_addr); n_fail++; end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (instr_rvalid !== 1'b1 || instr_rdata !== 32'hDEADBEEF || instr_err !== 1'b0) begin
      $display("FAIL fetch_resp: got v=%b d=%h e=%b, want 1 deadbeef 0", instr_rvalid, instr_rdata, instr_err); n_fail++; end
    n_checks++; if (data_rvalid !== 1'b0 || data_rdata !== 32'h0) begin
      $display("FAIL fetch_other: got dv=%b dd=%h, want 0 0", data_rvalid, data_rdata); n_fail++; end
  endtask

  // Both ports request every cycle: data wins 4, instr wins the 5th.
  // prev: 0 none, 1 instr, 2 data.
  task automatic test_starvation(input int cycles);
    int prev = 0;
    for (int i = 0; i < cycles; i++) begin
      logic iw;
      iw = ((i % 5) == 4);
      drive_cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0);
      n_checks++; if (instr_gnt !== iw || data_gnt !== !iw) begin
        $display("FAIL starve_gnt[%0d]: got i=%b d=%b, want i=%b d=%b", i, instr_gnt, data_gnt, iw, !iw); n_fail++; end
      n_checks++; if (rom_cs !== 1'b1 || rom_addr !== (iw ? 32'h40 : 32'h20)) begin
        $display("FAIL starve_rom[%0d]: got cs=%b addr=%h, want 1 %h", i, rom_cs, rom_addr, iw ? 32'h40 : 32'h20); n_fail++; end
      n_checks++; if (instr_rvalid !== (prev == 1) || data_rvalid !== (prev == 2)) begin
        $display("FAIL starve_rvalid[%0d]: got iv=%b dv=%b, want owner %0d", i, instr_rvalid, data_rvalid, prev); n_fail++; end
      if (prev == 1) begin
        n_checks++; if (instr_rdata !== rom_fn(30'h10)) begin
          $display("FAIL starve_irdata[%0d]: got %h, want %h", i, instr_rdata, rom_fn(30'h10)); n_fail++; end
      end else if (prev == 2) begin
        n_checks++; if (data_rdata !== rom_fn(30'h8)) begin
          $display("FAIL starve_drdata[%0d]: got %h, want %h", i, data_rdata, rom_fn(30'h8)); n_fail++; end
      end
      prev = iw ? 1 : 2;
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (instr_rvalid !== (prev == 1) || data_rvalid !== (prev == 2)) begin
      $display("FAIL starve_tail: got iv=%b dv=%b, want owner %0d", instr_rvalid, data_rvalid, prev); n_fail++; end
  endtask

  task automatic test_write_err();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    n_checks++; if (data_gnt !== 1'b1 || rom_cs !== 1'b0) begin
      $display("FAIL write_gnt: got gnt=%b cs=%b, want 1 0", data_gnt, rom_cs); n_fail++; end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (data_rvalid !== 1'b1 || data_err !== 1'b1 || data_rdata !== 32'h0) begin
      $display("FAIL write_resp: got v=%b e=%b d=%h, want 1 1 0", data_rvalid, data_err, data_rdata); n_fail++; end
  endtask

  task automatic test_range();
    // last legal word
    drive_cycle(1'b0, 1'b1, 32'h0000_7FFC, 1'b0, 32'h0, 1'b0);
    n_checks++; if (instr_gnt !== 1'b1 || rom_cs !== 1'b1) begin
      $display("FAIL range_last_gnt: got gnt=%b cs=%b, want 1 1", instr_gnt, rom_cs); n_fail++; end
    // first out-of-range word
    drive_cycle(1'b0, 1'b1, 32'h0000_8000, 1'b0, 32'h0, 1'b0);
    n_checks++; if (instr_rvalid !== 1'b1 || instr_err !== 1'b0 || instr_rdata !== rom_fn(30'd8191)) begin
      $display("FAIL range_last_resp: got v=%b e=%b d=%h, want 1 0 %h", instr_rvalid, instr_err, instr_rdata, rom_fn(30'd8191)); n_fail++; end
    n_checks++; if (instr_gnt !== 1'b1 || rom_cs !== 1'b0) begin
      $display("FAIL range_oob_gnt: got gnt=%b cs=%b, want 1 0", instr_gnt, rom_cs); n_fail++; end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (instr_rvalid !== 1'b1 || instr_err !== 1'b1 || instr_rdata !== 32'h0) begin
      $display("FAIL range_oob_resp: got v=%b e=%b d=%h, want 1 1 0", instr_rvalid, instr_err, instr_rdata); n_fail++; end
  endtask

  task automatic test_reset_midflight();
    // build up instr wait count with data winning 4 times
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0);
    n_checks++; if (data_gnt !== 1'b1) begin
      $display("FAIL midrst_pre_gnt: got %b, want 1", data_gnt); n_fail++; end
    drive_cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0);
    n_checks++; if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0) begin
      $display("FAIL midrst_drop: got dv=%b iv=%b, want 0 0", data_rvalid, instr_rvalid); n_fail++; end
    n_checks++; if (data_gnt !== 1'b0 || instr_gnt !== 1'b0 || rom_cs !== 1'b0) begin
      $display("FAIL midrst_gnt: got d=%b i=%b cs=%b, want 0", data_gnt, instr_gnt, rom_cs); n_fail++; end
    // counters cleared: data wins 4 again, instr the 5th
    for (int i = 0; i < 5; i++) begin
      logic iw;
      iw = (i == 4);
      drive_cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0);
      n_checks++; if (instr_gnt !== iw || data_gnt !== !iw) begin
        $display("FAIL midrst_post[%0d]: got i=%b d=%b, want i=%b d=%b", i, instr_gnt, data_gnt, iw, !iw); n_fail++; end
      if (i == 0) begin
        n_checks++; if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0) begin
          $display("FAIL midrst_first_rvalid: got dv=%b iv=%b, want 0 0", data_rvalid, instr_rvalid); n_fail++; end
      end
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    HRESET = 1'b1; instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_addr = '0; data_we = 1'b0;
    test_reset();
    test_fetch();
    test_starvation(10);
    test_write_err();
    test_range();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
